// File: rtl/regfile_pkg.sv
// Package: regfile_pkg
// Purpose: shared defaults and helpers for the multiport register file.
//   DATA_W_DEF / ADDR_W_DEF : default entry width and address width
//   DEPTH_DEF               : default number of entries (1 << ADDR_W_DEF)
//   addr_ext_t              : widest supported address, used by the helpers
//   wr_collide()            : true when both write ports target the same entry
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Addresses are zero-extended to this width before comparison, so the
    // helper works for any ADDR_W up to ADDR_W_MAX.
    localparam int ADDR_W_MAX = 16;
    typedef logic [ADDR_W_MAX-1:0] addr_ext_t;

    // Both ports commit to the same entry this cycle. The enables passed in
    // must already exclude dropped writes (address 0 with ZERO_REG).
    function automatic logic wr_collide(input logic      en0,
                                        input logic      en1,
                                        input addr_ext_t a0,
                                        input addr_ext_t a1);
        return en0 && en1 && (a0 == a1);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// Module: regfile_read_port
// Purpose: one synchronous read port of the register file. Selects between the
//   hardwired zero entry, same-cycle write forwarding, a pending clear, the
//   valid bit and the stored word, and registers the result when re=1.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   re, ra            read enable and read address
//   we0/wa0/wd0       write port 0 (forwarding source)
//   we1/wa1/wd1       write port 1 (forwarding source, higher priority)
//   clr               clear of all valid bits this cycle
//   entry_valid       valid bit of entry ra (pre-edge)
//   entry_data        stored word of entry ra (pre-edge)
//   rd                registered read data
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              clr,
    input  logic              entry_valid,
    input  logic [DATA_W-1:0] entry_data,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] rd_next;

    // NOTE: give every combinational output a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        rd_next = '0;
        if (ZERO_REG && (ra == '0)) begin
            rd_next = '0;
        end else if (BYPASS && we1 && (wa1 == ra)) begin
            rd_next = wd1;
        end else if (BYPASS && we0 && (wa0 == ra)) begin
            rd_next = wd0;
        end else if (clr || !entry_valid) begin
            rd_next = '0;
        end else begin
            rd_next = entry_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
        end else if (re) begin
            rd <= rd_next;
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// Module: multiport_regfile
// Purpose: 2-write / 2-read register file with per-entry valid bits,
//   optional hardwired zero entry and optional write-to-read forwarding.
//   Reads have one cycle of latency; unwritten or cleared entries read as 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               clears all valid bits at the edge (writes still commit)
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1, wins when both ports hit the same entry
//   re_a/ra_a/rd_a    read port A (enable, address, registered data)
//   re_b/ra_b/rd_b    read port B (enable, address, registered data)
//   wr_conflict       one-cycle pulse after both ports wrote the same entry
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] ra_a,
    output logic [DATA_W-1:0] rd_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_b,
    output logic              wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Writes that actually commit: address 0 is dropped when it is hardwired.
    logic commit0, commit1, collision;

    assign commit0   = we0 && !(ZERO_REG && (wa0 == '0));
    assign commit1   = we1 && !(ZERO_REG && (wa1 == '0));
    assign collision = wr_collide(commit0, commit1,
                                  addr_ext_t'(wa0), addr_ext_t'(wa1));

    // NOTE: the data array has no reset; the valid bits alone make stale
    // contents unobservable, and leaving it unreset lets it map to RAM.
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (commit0) mem[wa0] <= wd0;
        if (commit1) mem[wa1] <= wd1;
    end

    // The clear is scheduled first so a same-cycle write re-sets its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clr)     valid      <= '0;
            if (commit0) valid[wa0] <= 1'b1;
            if (commit1) valid[wa1] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= collision;
        end
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .clk         (clk),
        .rst         (rst),
        .re          (re_a),
        .ra          (ra_a),
        .we0         (we0),
        .wa0         (wa0),
        .wd0         (wd0),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .clr         (clr),
        .entry_valid (valid[ra_a]),
        .entry_data  (mem[ra_a]),
        .rd          (rd_a)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .clk         (clk),
        .rst         (rst),
        .re          (re_b),
        .ra          (ra_b),
        .we0         (we0),
        .wa0         (wa0),
        .wd0         (wd0),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .clr         (clr),
        .entry_valid (valid[ra_b]),
        .entry_data  (mem[ra_b]),
        .rd          (rd_b)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// Module: tb_multiport_regfile
// Purpose: directed bench for multiport_regfile. Two instances share every
//   input: dut_zb (ZERO_REG=1, BYPASS=1) and dut_nn (ZERO_REG=0, BYPASS=0),
//   so each vector exercises both parameter corners at once.
module tb_multiport_regfile;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [AW-1:0] wa0 = '0, wa1 = '0, ra_a = '0, ra_b = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;

    logic [DW-1:0] rd_a_zb, rd_b_zb, rd_a_nn, rd_b_nn;
    logic          conf_zb, conf_nn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_zb (
        .clk(clk), .rst(rst), .clr(clr),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .re_a(re_a), .ra_a(ra_a), .rd_a(rd_a_zb),
        .re_b(re_b), .ra_b(ra_b), .rd_b(rd_b_zb),
        .wr_conflict(conf_zb)
    );

    multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nn (
        .clk(clk), .rst(rst), .clr(clr),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .re_a(re_a), .ra_a(ra_a), .rd_a(rd_a_nn),
        .re_b(re_b), .ra_b(ra_b), .rd_b(rd_b_nn),
        .wr_conflict(conf_nn)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; re_a = 1'b0; re_b = 1'b0; clr = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we0 = 1'b1; wa0 = a; wd0 = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we1 = 1'b1; wa1 = a; wd1 = d;
    endtask

    task automatic rda(input logic [AW-1:0] a);
        re_a = 1'b1; ra_a = a;
    endtask

    task automatic rdb(input logic [AW-1:0] a);
        re_b = 1'b1; ra_b = a;
    endtask

    initial begin
        // Reset
        #2 rst = 1'b1;
        #1;
        check("reset rd_a zb", rd_a_zb, '0);
        check("reset rd_b nn", rd_b_nn, '0);
        check("reset conflict zb", {31'd0, conf_zb}, '0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // 1: unwritten entries read 0, then a write is visible next cycle
        rda(8'd5); rdb(8'd0);
        tick();
        check("t1 unwritten a zb", rd_a_zb, '0);
        check("t1 unwritten b nn", rd_b_nn, '0);
        idle(); wr0(8'd5, 32'hDEADBEEF);
        tick();
        idle(); rda(8'd5);
        tick();
        check("t1 readback zb", rd_a_zb, 32'hDEADBEEF);
        check("t1 readback nn", rd_a_nn, 32'hDEADBEEF);

        // 2: colliding writes to address 0
        idle(); wr0(8'd0, 32'h1234); wr1(8'd0, 32'h1234);
        tick();
        check("t2 zero conflict zb", {31'd0, conf_zb}, 32'd0);
        check("t2 zero conflict nn", {31'd0, conf_nn}, 32'd1);
        idle(); rda(8'd0);
        tick();
        check("t2 zero read zb", rd_a_zb, '0);
        check("t2 zero read nn", rd_a_nn, 32'h1234);
        check("t2 conflict drop nn", {31'd0, conf_nn}, 32'd0);

        // 3: same-address collision, port 1 wins
        idle(); wr0(8'd7, 32'hAAAA); wr1(8'd7, 32'h5555);
        tick();
        check("t3 conflict zb", {31'd0, conf_zb}, 32'd1);
        check("t3 conflict nn", {31'd0, conf_nn}, 32'd1);
        idle(); rda(8'd7);
        tick();
        check("t3 conflict pulse zb", {31'd0, conf_zb}, 32'd0);
        check("t3 winner zb", rd_a_zb, 32'h5555);
        check("t3 winner nn", rd_a_nn, 32'h5555);

        // 4: forwarding vs read-first
        idle(); wr0(8'd9, 32'h11);
        tick();
        idle(); wr0(8'd9, 32'h22); rda(8'd9);
        tick();
        check("t4 fwd zb", rd_a_zb, 32'h22);
        check("t4 old nn", rd_a_nn, 32'h11);
        idle(); wr0(8'd9, 32'h33); wr1(8'd9, 32'h44); rdb(8'd9);
        tick();
        check("t4 fwd port1 zb", rd_b_zb, 32'h44);
        check("t4 old b nn", rd_b_nn, 32'h22);

        // 5: clear with a same-cycle write
        idle(); wr0(8'd1, 32'h10); wr1(8'd2, 32'h20);
        tick();
        idle(); wr0(8'd3, 32'h30);
        tick();
        idle(); clr = 1'b1; wr0(8'd2, 32'h99); rda(8'd2); rdb(8'd3);
        tick();
        check("t5 clr fwd a zb", rd_a_zb, 32'h99);
        check("t5 clr a nn", rd_a_nn, '0);
        check("t5 clr b zb", rd_b_zb, '0);
        idle(); rda(8'd1); rdb(8'd2);
        tick();
        check("t5 entry1 zb", rd_a_zb, '0);
        check("t5 entry2 zb", rd_b_zb, 32'h99);
        check("t5 entry2 nn", rd_b_nn, 32'h99);
        idle(); rda(8'd3); rdb(8'd5);
        tick();
        check("t5 entry3 nn", rd_a_nn, '0);
        check("t5 entry5 zb", rd_b_zb, '0);

        // 6: read enable hold, then asynchronous reset
        idle(); rda(8'd2);
        tick();
        check("t6 pre-hold zb", rd_a_zb, 32'h99);
        idle(); ra_a = 8'd1;
        tick();
        ra_a = 8'd7;
        tick();
        check("t6 hold zb", rd_a_zb, 32'h99);
        check("t6 hold nn", rd_a_nn, 32'h99);
        #2 rst = 1'b1;
        #1;
        check("t6 async rd_a zb", rd_a_zb, '0);
        check("t6 async rd_a nn", rd_a_nn, '0);
        #2 rst = 1'b0;
        rda(8'd2); rdb(8'd7);
        tick();
        check("t6 post-rst 2 zb", rd_a_zb, '0);
        check("t6 post-rst 7 nn", rd_b_nn, '0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
